ps2_key_tx: RTL and testbench
=============================

// Module: ps2_key_tx
// PURPOSE
//  Serializes hps_io ps2_key events into PS/2 device-side clk/data waveforms for comp's keyboard input.
//  Each key event becomes scan-set-2 bytes (optional E0 prefix, optional F0 break prefix, scancode).
//  The bytes are queued and sent as 11-bit PS/2 frames.
//  Sits in emu between hps_io.ps2_key and comp.ps2_kbd_clk/ps2_kbd_data.
// PARAMETERS
//  HALF_PERIOD      2000      clk_sys cycles per PS/2 clock half-phase (12.5 kHz at 50 MHz)
//  GAP_CYCLES       8000      idle-high cycles enforced after each frame stop bit
//  FIFO_DEPTH       8         byte queue depth, power of 2, >=4
//  TYPEMATIC_DELAY  25000000  cycles a key is held before the first repeat (PS2TX_TYPEMATIC_EN only)
//  TYPEMATIC_PERIOD 5000000   cycles between repeats (PS2TX_TYPEMATIC_EN only)
// PORTS
//  clk_sys       in   1   system clock; all logic is on its rising edge
//  reset         in   1   synchronous, active-high
//  ps2_key       in   11  [7:0] code, [8] extended, [9] pressed, [10] toggles once per event
//  ps2_kbd_clk   out  1   PS/2 clock to comp; idle 1
//  ps2_kbd_data  out  1   PS/2 data to comp; idle 1
//  busy          out  1   1 while the FIFO is non-empty, a frame is active, or a gap is active
//  overflow      out  1   sticky: an event was dropped; cleared by reset only
// BEHAVIOUR
//  Reset (sync, active-high): clk=1, data=1, busy=0, overflow=0, FIFO empty, FSM IDLE.
//   During reset, the toggle shadow loads ps2_key[10], so no spurious event occurs after reset.
//  Event detect: ps2_key[10] != shadow -> shadow updated, event latched in the same cycle.
//  Enqueue sequencer pushes 1 byte/cycle:
//   - E0 if [8]=1
//   - then F0 if [9]=0
//   - then code
//   Event needs N = 1..3 bytes.
//  Admission is all-or-nothing: if FIFO free slots < N, or the sequencer is still pushing,
//   the whole event is dropped and overflow is set. Queued bytes are never partially written.
//  Frame = {start 0, d0..d7 LSB first, odd parity, stop 1}; parity = ~^byte.
//  FSM states:
//   IDLE -> LOAD when FIFO non-empty; LOAD pops the byte and builds the 11-bit shift register.
//   LOAD -> HI.
//   HI: clk=1, data=current bit for HALF_PERIOD cycles -> LO.
//   LO: clk=0, data held for HALF_PERIOD cycles.
//    After bit 10 -> GAP, otherwise shift and go to HI.
//   GAP: clk=1, data=1 for GAP_CYCLES -> IDLE.
//  Data changes only while clk=1; comp samples on the falling edge of clk.
//  Byte period = 22*HALF_PERIOD + GAP_CYCLES + 2 cycles (LOAD + IDLE).
//  Push and pop in the same cycle are both honoured; count is unchanged.
//  Pointers wrap modulo FIFO_DEPTH.
//  Reset mid-frame: outputs return high on the next edge; the frame is abandoned and the FIFO is cleared.
// CONFIGURATION
//  PS2TX_TYPEMATIC_EN defined:
//   The last make event (pressed=1) arms a repeat counter.
//   After TYPEMATIC_DELAY cycles, and then every TYPEMATIC_PERIOD cycles, it enqueues [E0] code.
//   The repeat uses the same all-or-nothing admission, but a refused repeat does NOT set overflow.
//   Any new ps2_key event disarms the counter, and re-arms it if that event is a make.
//  PS2TX_TYPEMATIC_EN undefined: no repeat logic; TYPEMATIC_* parameters are unused.
// STRUCTURE
//  Package ps2tx_pkg: constants PS2_EXT_PREFIX=8'hE0, PS2_BREAK_PREFIX=8'hF0, PS2_FRAME_BITS=11;
//   typedef enum {IDLE, LOAD, HI, LO, GAP} ps2tx_state_t.
//  Sub-module ps2tx_fifo: synchronous byte FIFO.
//   Ports: push, din, pop, dout, count; first-word-fall-through.
//  The top holds the event detect, enqueue sequencer, frame FSM/half-period counter and typematic counter.
// TESTING
//  Bench settings: HALF_PERIOD=4, GAP_CYCLES=8, FIFO_DEPTH=8.
//  1. Toggle with code=8'h1C, ext=0, pressed=1 -> one frame; bits on clk falls: 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
//     busy drops 8 cycles after the stop-bit low phase ends.
//  2. Toggle with code=8'h75, ext=1, pressed=0 -> frames E0, F0, 75 back-to-back with 8-cycle gaps.
//     Each frame's parity is correct; overflow stays 0.
//  3. Three ext-release events in quick succession (9 bytes) -> first two events (6 bytes) queue;
//     the third is dropped whole; overflow=1; exactly 6 frames are output.
//  4. Assert reset during bit 5 of a frame -> next cycle clk=1, data=1, busy=0;
//     no further edges; a toggle already present at reset does not produce a frame.
//  5. Check clk is low for exactly 4 cycles per bit;
//     the data-change assertion never fires while clk=0 (checked by an SVA over all runs).
//  6. With PS2TX_TYPEMATIC_EN, TYPEMATIC_DELAY=200, TYPEMATIC_PERIOD=100:
//     hold make 1C -> frames at event, +200, +300...; a release event stops repeats.

Source files
------------

// File: rtl/ps2tx_pkg.sv
// Shared constants, FSM state type and frame builder for the PS/2 keyboard transmitter.
// Optional typematic repeat is enabled by defining PS2TX_TYPEMATIC_EN.
package ps2tx_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  typedef enum logic [2:0] {IDLE, LOAD, HI, LO, GAP} ps2tx_state_t;

  // Bit 0 goes out first: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO; DEPTH must be a power of two.
// Simultaneous push and pop are both honoured, including when full.
module ps2tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_tx.sv
// Converts hps_io ps2_key events into scan-set-2 PS/2 device frames on ps2_kbd_clk/ps2_kbd_data.
// Define PS2TX_TYPEMATIC_EN to add auto-repeat of the last held make code.
module ps2_key_tx
  import ps2tx_pkg::*;
#(
  parameter int HALF_PERIOD      = 2000,
  parameter int GAP_CYCLES       = 8000,
  parameter int FIFO_DEPTH       = 8,
  parameter int TYPEMATIC_DELAY  = 25000000,
  parameter int TYPEMATIC_PERIOD = 5000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_kbd_clk,
  output logic        ps2_kbd_data,
  output logic        busy,
  output logic        overflow
);

  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int HW      = $clog2(CNT_MAX + 1);

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HALF_PERIOD < 1 ||
      GAP_CYCLES < 1 || TYPEMATIC_DELAY < 1 || TYPEMATIC_PERIOD < 1) begin : g_param_check
    $error("ps2_key_tx: illegal parameter value");
  end

  logic [7:0]    key_code;
  logic          key_ext;
  logic          key_pressed;
  logic          toggle_q;
  logic          event_hit;
  logic [23:0]   evt_buf;
  logic [1:0]    evt_n;
  logic          evt_ok;

  logic [1:0]    seq_cnt;
  logic [23:0]   seq_buf;
  logic          seq_idle;

  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free_slots;

  ps2tx_state_t  state, state_nxt;
  logic [HW-1:0] hcnt, hcnt_nxt;
  logic [3:0]    bit_idx, bit_idx_nxt;
  logic [PS2_FRAME_BITS-1:0] shreg, shreg_nxt;

  assign key_code    = ps2_key[7:0];
  assign key_ext     = ps2_key[8];
  assign key_pressed = ps2_key[9];
  assign event_hit   = ps2_key[10] != toggle_q;
  assign seq_idle    = seq_cnt == 2'd0;
  assign free_slots  = CW'(FIFO_DEPTH) - fifo_count;
  assign evt_ok      = event_hit && seq_idle && (free_slots >= CW'(evt_n));

  // Byte 0 of the buffer is pushed first.
  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    evt_buf = {16'h0000, key_code};
    evt_n   = 2'd1;
    case ({key_ext, key_pressed})
      2'b00:   begin evt_buf = {8'h00, key_code, PS2_BREAK_PREFIX};         evt_n = 2'd2; end
      2'b10:   begin evt_buf = {key_code, PS2_BREAK_PREFIX, PS2_EXT_PREFIX}; evt_n = 2'd3; end
      2'b11:   begin evt_buf = {8'h00, key_code, PS2_EXT_PREFIX};           evt_n = 2'd2; end
      default: ;
    endcase
  end

`ifdef PS2TX_TYPEMATIC_EN
  logic          rpt_armed;
  logic [31:0]   rpt_cnt;
  logic [7:0]    rpt_code;
  logic          rpt_ext;
  logic          rpt_ok;
  logic [23:0]   rpt_buf;
  logic [1:0]    rpt_n;

  assign rpt_buf = rpt_ext ? {8'h00, rpt_code, PS2_EXT_PREFIX} : {16'h0000, rpt_code};
  assign rpt_n   = rpt_ext ? 2'd2 : 2'd1;
  assign rpt_ok  = rpt_armed && (rpt_cnt == 32'd0) && !event_hit && seq_idle &&
                   (free_slots >= CW'(rpt_n));

  // Every event restarts the delay; only a make leaves the repeat armed.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rpt_armed <= 1'b0;
      rpt_cnt   <= '0;
      rpt_code  <= '0;
      rpt_ext   <= 1'b0;
    end else if (event_hit) begin
      rpt_armed <= key_pressed;
      rpt_cnt   <= 32'(TYPEMATIC_DELAY - 1);
      rpt_code  <= key_code;
      rpt_ext   <= key_ext;
    end else if (rpt_armed) begin
      rpt_cnt   <= (rpt_cnt == 32'd0) ? 32'(TYPEMATIC_PERIOD - 1) : rpt_cnt - 32'd1;
    end
  end
`endif

  // Admission is decided in the event cycle; the sequencer then pushes one byte per cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q <= ps2_key[10];
      seq_cnt  <= '0;
      seq_buf  <= '0;
      overflow <= 1'b0;
    end else begin
      toggle_q <= ps2_key[10];
      if (!seq_idle) begin
        seq_buf <= {8'h00, seq_buf[23:8]};
        seq_cnt <= seq_cnt - 2'd1;
      end
      if (evt_ok) begin
        seq_buf <= evt_buf;
        seq_cnt <= evt_n;
      end else if (event_hit) begin
        overflow <= 1'b1;
`ifdef PS2TX_TYPEMATIC_EN
      end else if (rpt_ok) begin
        seq_buf <= rpt_buf;
        seq_cnt <= rpt_n;
`endif
      end
    end
  end

  ps2tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (!seq_idle),
    .din     (seq_buf[7:0]),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .count   (fifo_count)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      hcnt    <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else begin
      state   <= state_nxt;
      hcnt    <= hcnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt + HW'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    fifo_pop    = 1'b0;
    case (state)
      IDLE: begin
        hcnt_nxt = '0;
        if (fifo_count != '0) state_nxt = LOAD;
      end
      LOAD: begin
        fifo_pop    = 1'b1;
        shreg_nxt   = ps2_frame(fifo_dout);
        bit_idx_nxt = '0;
        hcnt_nxt    = '0;
        state_nxt   = HI;
      end
      HI: begin
        if (hcnt == HW'(HALF_PERIOD - 1)) begin
          hcnt_nxt  = '0;
          state_nxt = LO;
        end
      end
      LO: begin
        if (hcnt == HW'(HALF_PERIOD - 1)) begin
          hcnt_nxt = '0;
          if (bit_idx == 4'(PS2_FRAME_BITS - 1)) begin
            state_nxt = GAP;
          end else begin
            shreg_nxt   = {1'b1, shreg[PS2_FRAME_BITS-1:1]};
            bit_idx_nxt = bit_idx + 4'd1;
            state_nxt   = HI;
          end
        end
      end
      GAP: begin
        if (hcnt == HW'(GAP_CYCLES - 1)) begin
          hcnt_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data only moves on transitions into HI, so it is stable across every clock fall.
  assign ps2_kbd_clk  = (state != LO);
  assign ps2_kbd_data = (state == HI || state == LO) ? shreg[0] : 1'b1;
  assign busy         = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_ps2_key_tx.sv
// Scoreboard bench for ps2_key_tx: stimulus pushes expected bytes, a waveform monitor decodes frames.
// Define PS2TX_TYPEMATIC_EN for both RTL and bench to exercise auto-repeat.
module tb_ps2_key_tx;

  localparam int HALF  = 4;
  localparam int GAPC  = 8;
  localparam int DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic        ps2_kbd_clk, ps2_kbd_data, busy, overflow;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int frames = 0;
  int falls  = 0;
  int mon_bitn = 0;
  int stop_rise_cycle = 0;
  int busy_fall_cycle = 0;
  logic [10:0] last_frame = '0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  ps2_key_tx #(
    .HALF_PERIOD(HALF), .GAP_CYCLES(GAPC), .FIFO_DEPTH(DEPTH),
    .TYPEMATIC_DELAY(200), .TYPEMATIC_PERIOD(100)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_key      (ps2_key),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cycle <= cycle + 1;

  a_data_stable: assert property (@(posedge clk_sys) $changed(ps2_kbd_data) |-> ps2_kbd_clk)
    else begin
      errors++;
      $display("FAIL data_change_while_clk_low at cycle %0d", cycle);
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: scan-set-2 byte sequence for one key event.
  function automatic void expect_event(input logic [7:0] code, input logic ext, input logic pressed);
    if (ext)      exp_q.push_back(8'hE0);
    if (!pressed) exp_q.push_back(8'hF0);
    exp_q.push_back(code);
  endfunction

  function automatic int event_len(input logic ext, input logic pressed);
    return 1 + int'(ext) + int'(!pressed);
  endfunction

  task automatic send_event(input logic [7:0] code, input logic ext, input logic pressed,
                            input int settle);
    @(negedge clk_sys);
    ps2_key = {~ps2_key[10], pressed, ext, code};
    repeat (settle) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    exp_q.delete();
    start_q.delete();
    repeat (3) @(negedge clk_sys);
    check("reset_clk", ps2_kbd_clk, 1'b1);
    check("reset_data", ps2_kbd_data, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    repeat (3) @(negedge clk_sys);
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check("drain_timeout", n < budget, 1'b1);
  endtask

  // Waveform monitor: decodes frames on clock falls and checks them against the scoreboard.
  initial begin : monitor
    logic       prev_k;
    logic       prev_busy;
    logic       stop_pending;
    int         low_len;
    logic [10:0] fr;
    logic [7:0] exp_b;
    prev_k = 1'b1; prev_busy = 1'b0; stop_pending = 1'b0; low_len = 0; fr = '0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mon_bitn = 0; prev_k = 1'b1; prev_busy = 1'b0; low_len = 0; stop_pending = 1'b0;
      end else begin
        if (prev_k && !ps2_kbd_clk) begin
          if (mon_bitn == 0) start_q.push_back(cycle);
          fr[mon_bitn] = ps2_kbd_data;
          mon_bitn++;
          falls++;
          if (mon_bitn == 11) begin
            mon_bitn = 0;
            frames++;
            last_frame = fr;
            stop_pending = 1'b1;
            check("start_bit", fr[0], 1'b0);
            check("stop_bit", fr[10], 1'b1);
            check("odd_parity", fr[9], ~^fr[8:1]);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame: got byte %0h with nothing expected", fr[8:1]);
            end else begin
              exp_b = exp_q.pop_front();
              check("frame_byte", fr[8:1], exp_b);
            end
          end
        end
        if (!ps2_kbd_clk) begin
          low_len++;
        end else if (!prev_k) begin
          check("clk_low_cycles", low_len, HALF);
          low_len = 0;
          if (stop_pending) begin
            stop_rise_cycle = cycle;
            stop_pending = 1'b0;
          end
        end
        if (prev_busy && !busy) busy_fall_cycle = cycle;
        prev_k = ps2_kbd_clk;
        prev_busy = busy;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int f0;
    int occ;
    int n;
    logic [7:0] code;
    logic ext, pressed;

    // 1: single make 1C, exact bit pattern and busy tail
    do_reset();
    f0 = frames;
    expect_event(8'h1C, 1'b0, 1'b1);
    send_event(8'h1C, 1'b0, 1'b1, 1);
    wait_drain(400);
    check("t1_frames", frames - f0, 1);
    check("t1_bits", last_frame, 11'b1_0_00011100_0);
    check("t1_busy_tail", busy_fall_cycle - stop_rise_cycle, GAPC);

    // 2: extended release -> E0 F0 75
    do_reset();
    f0 = frames;
    expect_event(8'h75, 1'b1, 1'b0);
    send_event(8'h75, 1'b1, 1'b0, 1);
    wait_drain(600);
    check("t2_frames", frames - f0, 3);
    check("t2_overflow", overflow, 1'b0);

    // 3: primer byte occupies the frame engine so no pop overlaps the 9-byte burst
    do_reset();
    f0 = frames;
    expect_event(8'h29, 1'b0, 1'b1);
    send_event(8'h29, 1'b0, 1'b1, 6);
    occ = 0;
    for (int i = 0; i < 3; i++) begin
      code = 8'($urandom);
      if (occ + event_len(1'b1, 1'b0) <= DEPTH) begin
        expect_event(code, 1'b1, 1'b0);
        occ += event_len(1'b1, 1'b0);
      end
      send_event(code, 1'b1, 1'b0, 4);
    end
    check("t3_overflow", overflow, 1'b1);
    wait_drain(1500);
    check("t3_frames", frames - f0, 7);
    check("t3_overflow_sticky", overflow, 1'b1);

    // 4: reset during bit 5, with a toggle arriving together with reset
    do_reset();
    expect_event(8'h5A, 1'b0, 1'b1);
    send_event(8'h5A, 1'b0, 1'b1, 0);
    n = 0;
    while (mon_bitn != 6 && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("t4_reach_bit5", n < 300, 1'b1);
    reset = 1'b1;
    ps2_key[10] = ~ps2_key[10];
    exp_q.delete();
    @(negedge clk_sys);
    check("t4_clk_high", ps2_kbd_clk, 1'b1);
    check("t4_data_high", ps2_kbd_data, 1'b1);
    check("t4_busy_low", busy, 1'b0);
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    f0 = falls;
    repeat (300) @(negedge clk_sys);
    check("t4_no_edges", falls - f0, 0);
    check("t4_idle", busy, 1'b0);

    // Randomized events, each admitted into an idle transmitter
    do_reset();
    f0 = frames;
    occ = 0;
    for (int i = 0; i < 10; i++) begin
      code = 8'($urandom);
      ext  = 1'($urandom_range(0, 1));
`ifdef PS2TX_TYPEMATIC_EN
      pressed = 1'b0;
`else
      pressed = 1'($urandom_range(0, 1));
`endif
      occ += event_len(ext, pressed);
      expect_event(code, ext, pressed);
      send_event(code, ext, pressed, 1);
      wait_drain(1000);
    end
    check("rand_frames", frames - f0, occ);
    check("rand_overflow", overflow, 1'b0);

`ifdef PS2TX_TYPEMATIC_EN
    // 6: held make repeats at +200, +300; release stops further repeats
    do_reset();
    f0 = frames;
    repeat (3) expect_event(8'h1C, 1'b0, 1'b1);
    send_event(8'h1C, 1'b0, 1'b1, 350);
    expect_event(8'h1C, 1'b0, 1'b0);
    send_event(8'h1C, 1'b0, 1'b0, 1);
    wait_drain(800);
    repeat (400) @(negedge clk_sys);
    check("t6_frames", frames - f0, 5);
    if (start_q.size() >= 3) begin
      check("t6_first_repeat", start_q[1] - start_q[0], 200);
      check("t6_second_repeat", start_q[2] - start_q[1], 100);
    end else begin
      checks++;
      errors++;
      $display("FAIL t6_repeat_starts: got %0d frame starts, need 3", start_q.size());
    end
    check("t6_overflow", overflow, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
